// File: rtl/sd_pkg.sv
// Shared types and default clock-divider constants for the RK8E SD-card SPI path.
// Provides the sequencer command encoding, master FSM states and SCLK half-periods.
package sd_pkg;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_CSL = 2'd1,
        OP_CSH = 2'd2,
        OP_TR  = 2'd3
    } spiOP_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2
    } state_t;

    localparam int SD_SLOW_HALF = 125;
    localparam int SD_FAST_HALF = 4;

endpackage

// File: rtl/sd_spi_master.sv
// Byte-wide mode-0 SPI master: executes CSL, CSH or an 8-bit full-duplex transfer.
// Ports: clk/reset (sync, active high), spiOP/spiTX/spiFAST command in,
//        spiRX/spiDONE/spiBUSY status out, sdCS/sdSCLK/sdMOSI/sdMISO card pins.
module sd_spi_master
    import sd_pkg::*;
#(
    parameter int SLOW_HALF = SD_SLOW_HALF,
    parameter int FAST_HALF = SD_FAST_HALF
) (
    input  logic       clk,
    input  logic       reset,
    input  spiOP_t     spiOP,
    input  logic [7:0] spiTX,
    input  logic       spiFAST,
    output logic [7:0] spiRX,
    output logic       spiDONE,
    output logic       spiBUSY,
    output logic       sdCS,
    output logic       sdSCLK,
    output logic       sdMOSI,
    input  logic       sdMISO
);

    localparam int MAX_HALF = (SLOW_HALF > FAST_HALF) ? SLOW_HALF : FAST_HALF;
    localparam int DW       = $clog2(MAX_HALF);

    localparam logic [DW-1:0] SLOW_RL = DW'(SLOW_HALF - 1);
    localparam logic [DW-1:0] FAST_RL = DW'(FAST_HALF - 1);

    state_t        state_q, state_d;
    logic          cs_q, cs_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic [7:0]    rx_q, rx_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          fast_q, fast_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;

    logic [DW-1:0] reload;

    // Divider reload follows the rate latched at the start of the transfer.
    assign reload = fast_q ? FAST_RL : SLOW_RL;

    always_comb begin
        state_d  = state_q;
        cs_d     = cs_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        rx_d     = rx_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        fast_d   = fast_q;
        div_d    = div_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;

        unique case (state_q)
            S_IDLE: begin
                unique case (spiOP)
                    OP_NOP: ;
                    OP_CSL: begin
                        cs_d   = 1'b0;
                        done_d = 1'b1;
                    end
                    OP_CSH: begin
                        cs_d   = 1'b1;
                        done_d = 1'b1;
                    end
                    OP_TR: begin
                        shift_d  = spiTX;
                        fast_d   = spiFAST;
                        div_d    = spiFAST ? FAST_RL : SLOW_RL;
                        bitcnt_d = 3'd0;
                        mosi_d   = spiTX[7];
                        busy_d   = 1'b1;
                        state_d  = S_LOW;
                    end
                    default: ;
                endcase
            end
            S_LOW: begin
                if (div_q == '0) begin
                    sclk_d  = 1'b1;
                    // MSB has already been presented on MOSI; the
                    // vacated LSB collects the incoming bit.
                    shift_d = {shift_q[6:0], sdMISO};
                    div_d   = reload;
                    state_d = S_HIGH;
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            S_HIGH: begin
                if (div_q == '0) begin
                    sclk_d = 1'b0;
                    if (bitcnt_q == 3'd7) begin
                        rx_d    = shift_q;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        mosi_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        bitcnt_d = bitcnt_q + 3'd1;
                        mosi_d   = shift_q[7];
                        div_d    = reload;
                        state_d  = S_LOW;
                    end
                end else begin
                    div_d = div_q - DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cs_q     <= 1'b1;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b1;
            rx_q     <= 8'h00;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            fast_q   <= 1'b0;
            div_q    <= '0;
            bitcnt_q <= 3'd0;
            shift_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            rx_q     <= rx_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            fast_q   <= fast_d;
            div_q    <= div_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
        end
    end

    assign spiRX   = rx_q;
    assign spiDONE = done_q;
    assign spiBUSY = busy_q;
    assign sdCS    = cs_q;
    assign sdSCLK  = sclk_q;
    assign sdMOSI  = mosi_q;

endmodule

// File: doc/sd_spi_master.md
# sd_spi_master

Byte-wide SPI master for the RK8E SD-card path. It sits between the RK8E disk-controller sequencer and the SD card pins (sdCS, sdSCLK, sdMOSI, sdMISO). It executes one command at a time from the sequencer: assert CS, deassert CS, or a full-duplex 8-bit transfer. It returns the received byte with a one-cycle done strobe. The SPI clock is selectable between a slow initialisation rate and a fast data rate.

## Interface
- SLOW_HALF, 125: clk cycles per SCLK half-period in slow mode (≥4).
- FAST_HALF, 4: clk cycles per SCLK half-period in fast mode (≥4).
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- spiOP  in  2  command (spiOP_t): NOP=0, CSL=1, CSH=2, TR=3; sampled only when idle.
- spiTX  in  8  byte to transmit, MSB first; sampled with TR.
- spiFAST  in  1  1 = FAST_HALF, 0 = SLOW_HALF; sampled with TR.
- spiRX  out  8  last received byte; held until the next TR completes.
- spiDONE  out  1  one-cycle pulse when a command completes.
- spiBUSY  out  1  high while a TR is in progress.
- sdCS  out  1  card select, active low.
- sdSCLK  out  1  SPI clock, idles low (mode 0).
- sdMOSI  out  1  master out; idles high.
- sdMISO  in  1  master in.

## Operation
- States: IDLE, LOW, HIGH (state_t).
- IDLE, spiOP=NOP: no action.
- IDLE, spiOP=CSL: sdCS←0 and spiDONE←1 on the next edge. Stay in IDLE.
- IDLE, spiOP=CSH: sdCS←1 and spiDONE←1 on the next edge. Stay in IDLE.
- IDLE, spiOP=TR:
  - Load the shift register with spiTX.
  - Latch the half-period from spiFAST into div (half-1).
  - Clear bitcnt to 0, set sdMOSI←spiTX[7], spiBUSY←1, go to LOW.
- TR does not touch sdCS. The sequencer brackets transfers with CSL/CSH.
- LOW: decrement div each cycle. At div=0:
  - sdSCLK←1.
  - Shift sdMISO into the shift-register LSB.
  - Reload div, go to HIGH.
- HIGH: decrement div each cycle. At div=0, sdSCLK←0, then:
  - If bitcnt=7: spiRX←shift, spiDONE←1, spiBUSY←0, sdMOSI←1, go to IDLE.
  - Otherwise: bitcnt+1, sdMOSI←next TX bit, reload div, go to LOW.
- MOSI changes only on SCLK falling edges or at the start of a TR. MISO is sampled on the rising edge.
- Any spiOP≠NOP while not IDLE is ignored entirely. It is not queued and produces no DONE.
- div width is $clog2(max(SLOW_HALF,FAST_HALF)). bitcnt is 3 bits.

## Timing
- Reset values: sdCS=1, sdSCLK=0, sdMOSI=1, spiRX=8'h00, spiDONE=0, spiBUSY=0, state=IDLE.
- Reset mid-transfer aborts immediately to the reset values. No DONE is issued.
- CSL/CSH latency: 1 cycle from the command to the pin change and DONE.
- TR latency: accepted at edge T. spiDONE is high for the cycle following edge T+16·HALF. The SCLK falling edge and DONE coincide.
- SCLK duty cycle: exactly HALF clk cycles high and HALF low per bit.
- Back-to-back: a new command may be presented in the same cycle spiDONE is high. It is accepted at that edge with no dead cycle.
- MISO must be stable within HALF−1 cycles of a falling edge. HALF≥4 satisfies the sdsim model's 3-cycle response lag.

## Structure
- Package sd_pkg: spiOP_t (2-bit enum), state_t, and default constants SD_SLOW_HALF and SD_FAST_HALF.
- Single module with no sub-module. The divider, bit counter and shift register are local.

## Test plan
- Reset: assert reset for 2 cycles. Expect sdCS=1, sdSCLK=0, sdMOSI=1, spiRX=00, spiDONE=0, spiBUSY=0.
- CS control:
  - CSL → sdCS=0 and a 1-cycle spiDONE one cycle later.
  - CSH → sdCS=1 and spiDONE.
- Loopback: tie sdMISO=sdMOSI, spiFAST=1, TR with spiTX=A5.
  - MOSI bits 1,0,1,0,0,1,0,1 across 8 SCLK pulses.
  - spiRX=A5; DONE exactly 65 cycles after acceptance.
- sdsim integration, slow mode:
  - CSL, then TR 40,00,00,00,00,95, then TR FF ×2.
  - Second FF transfer returns spiRX=01 (CMD0 R1 idle).
- Busy rules: issue CSH and TR while a TR is in progress.
  - sdCS is unchanged and no extra DONE occurs.
  - The in-flight byte completes correctly.
- Reset mid-transfer: reset at bit 4 of a TR.
  - Pins return to reset values next cycle, no DONE.
  - A following TR FF in loopback yields FF.
